audio_playback_sequencer: RTL and testbench
===========================================

Name: audio_playback_sequencer

Overview:
Sample-rate playback controller between the configuration/ROM stage and the bit serializer of the WM8731 audio path. Once per DAC_LR_CLK frame it:
- generates the sample ROM address and read enable over a programmable [start,end] window, with loop, pause/resume and end-of-clip detection;
- scales each returned sample by a soft-ramped volume gain (click-free start/pause);
- presents one signed 16-bit sample per frame to the serializer.

Parameters:
ADDR_W, 18, ROM address width
DATA_W, 16, sample width (signed two's complement)
RAMP_DIV, 64, frames per one-step gain change (>=1)

Ports:
DAC_LR_CLK  input  1  frame clock; one rising edge per stereo frame
reset  input  1  synchronous, active-low
enable  input  1  codec configuration complete; low forces IDLE
play  input  1  level: 1 = play/resume, 0 = pause
loop_en  input  1  wrap to start_addr at end_addr instead of stopping
start_addr  input  ADDR_W  first sample address (latched on IDLE->RUN)
end_addr  input  ADDR_W  last sample address inclusive (latched on IDLE->RUN)
vol  input  4  target volume 0..15; 15 maps to gain 16 (unity)
rom_data  input  DATA_W  ROM output for address issued previous frame
rom_addr  output  ADDR_W  ROM read address
rom_rden  output  1  ROM read enable
sample_out  output  DATA_W  scaled sample to serializer
sample_valid  output  1  sample_out holds a real sample this frame
playing  output  1  state is RUN
done  output  1  one-frame pulse at end of non-looping clip

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE, rom_addr=0, rom_rden=0, sample_out=0, sample_valid=0, gain=0, playing=0, done=0, play_q=0. Applies mid-operation identically; latched window is discarded.
- enable=0 in any state: next state IDLE, rom_rden=0, gain=0; outputs as at reset except rom_addr, which holds.
- Gain g: 5-bit unsigned, 0..16. Target gt = (state RUN and play) ? (vol==15 ? 16 : vol) : 0. A divider counts 0..RAMP_DIV-1. On its wrap, g moves one step toward gt; equal means no change. A vol change re-targets without restarting the divider.
- Scaling: product = signed(rom_data) * signed({1'b0,g}) at 21 bits, followed by an arithmetic right shift of 4, truncated to DATA_W. No saturation is needed because g<=16. g=16 is an exact pass-through; g=0 gives 0.
- Pipeline: address A is issued on edge k with rom_rden=1. At edge k+1, rom_data(A) is sampled, and sample_out and sample_valid=1 are registered. Latency from address to sample_out is therefore 1 frame. sample_valid = rom_rden delayed 1 frame. When sample_valid=0, sample_out=0.
- States:
  IDLE: rom_rden=0. On enable and a rising edge of play (play & ~play_q): latch the window, rom_addr<=start_addr, rom_rden<=1, go to RUN. If start_addr>end_addr: pulse done and stay in IDLE, no ROM reads.
  RUN: playing=1, rom_rden=1.
    - Each frame: rom_addr <= rom_addr+1.
    - If rom_addr==end_addr: with loop_en, rom_addr<=start_addr (latched); without loop_en, go to DONE and rom_rden<=0.
    - If play=0 and g==0: go to PAUSE, rom_rden<=0, rom_addr holds the next unread address.
  PAUSE: rom_rden=0, g=0. If play=1, go to RUN resuming at the held address; the gain ramps up from 0.
  DONE: done=1 for exactly this frame, rom_rden=0, g<=0, next state IDLE. A new start needs a fresh play rising edge.
- start_addr==end_addr: single sample per pass; with loop_en the same address repeats every frame.
- While paused, fade-out continues reading (rom_rden=1) until g reaches 0, so there is no hard cut.
- Changes to start_addr/end_addr/loop_en: the window and loop_en are sampled in RUN each frame, except the window itself, which uses latched values only.

Test Plan:
1. start=0, end=3, loop_en=0, vol=15, RAMP_DIV=1, play rising -> rom_addr 0,1,2,3. sample_valid high 4 frames, each one frame after its address. done pulses the frame after address 3 issues. Then IDLE with rom_rden=0.
2. rom_data=16'h7FFF constant, vol=15, RAMP_DIV=4 -> g steps 0->16 over 64 frames. sample_out at g=8 is 16'h3FFF; at g=16 it is 16'h7FFF. rom_data=16'h8000, g=16 -> 16'h8000.
3. loop_en=1, start=10, end=12 -> addresses 10,11,12,10,11,... and done never asserts.
4. Play then drop play at address 20 with g=16, RAMP_DIV=1 -> reads continue 16 frames while g counts down to 0, then PAUSE with rom_addr held. Raise play -> resumes at the held address with g ramping from 0.
5. start=5, end=4, play rising -> done pulse, no rom_rden. Also start==end=7, loop_en=1 -> rom_addr stays 7 with rden=1.
6. reset=0 mid-RUN at address 100 -> next frame all outputs at reset values. enable=0 mid-RUN -> IDLE, rden=0.

Source files
------------

// File: rtl/audio_playback_sequencer_if.sv
// audio_playback_sequencer_if: control, ROM and serializer signals of the playback sequencer
interface audio_playback_sequencer_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   logic              enable;
   logic              play;
   logic              loop_en;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_addr;
   logic [3:0]        vol;
   logic [DATA_W-1:0] rom_data;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_rden;
   logic [DATA_W-1:0] sample_out;
   logic              sample_valid;
   logic              playing;
   logic              done;
   modport master (
      output enable, play, loop_en, start_addr, end_addr, vol, rom_data,
      input  rom_addr, rom_rden, sample_out, sample_valid, playing, done
   );
   modport slave (
      input  enable, play, loop_en, start_addr, end_addr, vol, rom_data,
      output rom_addr, rom_rden, sample_out, sample_valid, playing, done
   );
endinterface

// File: rtl/audio_playback_sequencer.sv
// audio_playback_sequencer: per-frame ROM address sequencer with soft-ramped volume scaling
module audio_playback_sequencer #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 16,
   parameter int RAMP_DIV = 64
) (
   input logic                       DAC_LR_CLK,
   input logic                       reset,
   audio_playback_sequencer_if.slave seq_if
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam int DW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
   localparam int PW = DATA_W + 5;
   logic [1:0]            state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d, start_q, start_d, end_q, end_d, addr_nx;
   logic                  rden_q, rden_d, done_q, done_d, valid_q, valid_d, play_q;
   logic [DATA_W-1:0]     sample_q, sample_d;
   logic [4:0]            gain_q, gain_d, gain_t;
   logic [DW-1:0]         div_q, div_d;
   logic                  wrap;
   logic signed [PW-1:0]  prod;
   assign addr_nx = addr_q == end_q ? start_q : addr_q + ADDR_W'(1);
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      start_d = start_q;
      end_d   = end_q;
      rden_d  = 1'b0;
      done_d  = 1'b0;
      if (!seq_if.enable) state_d = IDLE;
      else case (state_q)
         IDLE: if (seq_if.play && !play_q) begin
            if (seq_if.start_addr > seq_if.end_addr) done_d = 1'b1;
            else begin
               state_d = RUN;
               start_d = seq_if.start_addr;
               end_d   = seq_if.end_addr;
               addr_d  = seq_if.start_addr;
               rden_d  = 1'b1;
            end
         end
         RUN: begin
            addr_d = addr_nx;
            if (addr_q == end_q && !seq_if.loop_en) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
            else if (!seq_if.play && gain_q == 5'd0) state_d = PAUSE;
            else rden_d = 1'b1;
         end
         PAUSE: if (seq_if.play) begin
            state_d = RUN;
            rden_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // Gain only moves toward its target on divider wrap; pause and end-of-clip force it to silence
   assign gain_t = (state_q == RUN && seq_if.play) ? (seq_if.vol == 4'hF ? 5'd16 : {1'b0, seq_if.vol}) : 5'd0;
   assign wrap   = div_q == DW'(RAMP_DIV - 1);
   assign div_d  = wrap ? '0 : div_q + DW'(1);
   assign gain_d = (!seq_if.enable || state_q == PAUSE || state_q == DONE) ? 5'd0 :
                   !wrap ? gain_q :
                   gain_q < gain_t ? gain_q + 5'd1 :
                   gain_q > gain_t ? gain_q - 5'd1 : gain_q;
   assign prod     = PW'($signed(seq_if.rom_data)) * PW'($signed({1'b0, gain_q}));
   assign valid_d  = seq_if.enable & rden_q;
   assign sample_d = valid_d ? DATA_W'(prod >>> 4) : '0;
   always_ff @(posedge DAC_LR_CLK) begin
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         start_q  <= '0;
         end_q    <= '0;
         rden_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         sample_q <= '0;
         gain_q   <= 5'd0;
         div_q    <= '0;
         play_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         start_q  <= start_d;
         end_q    <= end_d;
         rden_q   <= rden_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         sample_q <= sample_d;
         gain_q   <= gain_d;
         div_q    <= div_d;
         play_q   <= seq_if.play;
      end
   end
   assign seq_if.rom_addr     = addr_q;
   assign seq_if.rom_rden     = rden_q;
   assign seq_if.sample_out   = sample_q;
   assign seq_if.sample_valid = valid_q;
   assign seq_if.playing      = state_q == RUN;
   assign seq_if.done         = done_q;
endmodule

// File: tb/tb_audio_playback_sequencer.sv
// tb_audio_playback_sequencer: directed vectors for the playback sequencer (ramp step 1 and 4)
module tb_audio_playback_sequencer;
   typedef struct {
      int rst, en, play, lp, sa, ea, vol, data;
      int e_addr, e_rden, e_samp, e_valid, e_play, e_done;
   } vec_t;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tv[28];
   always #5 clk = ~clk;
   audio_playback_sequencer_if #(.ADDR_W(18), .DATA_W(16)) ifa ();
   audio_playback_sequencer_if #(.ADDR_W(18), .DATA_W(16)) ifb ();
   audio_playback_sequencer #(.ADDR_W(18), .DATA_W(16), .RAMP_DIV(1)) dut_a (
      .DAC_LR_CLK(clk), .reset(rst_a), .seq_if(ifa));
   audio_playback_sequencer #(.ADDR_W(18), .DATA_W(16), .RAMP_DIV(4)) dut_b (
      .DAC_LR_CLK(clk), .reset(rst_b), .seq_if(ifb));
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   initial begin
      // rst en play lp sa ea vol data | addr rden samp valid playing done
      tv[0]  = '{0, 0, 0, 0,  0,  3, 15, 'h0100,  0, 0, 'h0000, 0, 0, 0};
      tv[1]  = '{1, 1, 0, 0,  0,  3, 15, 'h0100,  0, 0, 'h0000, 0, 0, 0};
      tv[2]  = '{1, 1, 1, 0,  0,  3, 15, 'h0100,  0, 1, 'h0000, 0, 1, 0};
      tv[3]  = '{1, 1, 1, 0,  0,  3, 15, 'h0100,  1, 1, 'h0000, 1, 1, 0};
      tv[4]  = '{1, 1, 1, 0,  0,  3, 15, 'h0100,  2, 1, 'h0010, 1, 1, 0};
      tv[5]  = '{1, 1, 1, 0,  0,  3, 15, 'h0100,  3, 1, 'h0020, 1, 1, 0};
      tv[6]  = '{1, 1, 1, 0,  0,  3, 15, 'h0100,  0, 0, 'h0030, 1, 0, 1};
      tv[7]  = '{1, 1, 1, 0,  0,  3, 15, 'h0100,  0, 0, 'h0000, 0, 0, 0};
      tv[8]  = '{1, 1, 1, 0,  0,  3, 15, 'h0100,  0, 0, 'h0000, 0, 0, 0};
      tv[9]  = '{1, 1, 0, 1, 10, 12, 15, 'h0100,  0, 0, 'h0000, 0, 0, 0};
      tv[10] = '{1, 1, 1, 1, 10, 12, 15, 'h0100, 10, 1, 'h0000, 0, 1, 0};
      tv[11] = '{1, 1, 1, 1, 10, 12, 15, 'h0100, 11, 1, 'h0000, 1, 1, 0};
      tv[12] = '{1, 1, 1, 1, 10, 12, 15, 'h0100, 12, 1, 'h0010, 1, 1, 0};
      tv[13] = '{1, 1, 1, 1, 10, 12, 15, 'h0100, 10, 1, 'h0020, 1, 1, 0};
      tv[14] = '{1, 1, 1, 1, 10, 12, 15, 'h0100, 11, 1, 'h0030, 1, 1, 0};
      tv[15] = '{1, 1, 1, 1, 10, 12, 15, 'hFF00, 12, 1, 'hFFC0, 1, 1, 0};
      tv[16] = '{1, 1, 1, 1, 10, 12, 15, 'hFF00, 10, 1, 'hFFB0, 1, 1, 0};
      tv[17] = '{1, 0, 1, 1, 10, 12, 15, 'hFF00, 10, 0, 'h0000, 0, 0, 0};
      tv[18] = '{1, 1, 1, 1, 10, 12, 15, 'h0100, 10, 0, 'h0000, 0, 0, 0};
      tv[19] = '{1, 1, 0, 0,  5,  4, 15, 'h0100, 10, 0, 'h0000, 0, 0, 0};
      tv[20] = '{1, 1, 1, 0,  5,  4, 15, 'h0100, 10, 0, 'h0000, 0, 0, 1};
      tv[21] = '{1, 1, 1, 0,  5,  4, 15, 'h0100, 10, 0, 'h0000, 0, 0, 0};
      tv[22] = '{1, 1, 0, 1,  7,  7, 15, 'h0100, 10, 0, 'h0000, 0, 0, 0};
      tv[23] = '{1, 1, 1, 1,  7,  7, 15, 'h0100,  7, 1, 'h0000, 0, 1, 0};
      tv[24] = '{1, 1, 1, 1,  7,  7, 15, 'h0100,  7, 1, 'h0000, 1, 1, 0};
      tv[25] = '{1, 1, 1, 1,  7,  7, 15, 'h0100,  7, 1, 'h0010, 1, 1, 0};
      tv[26] = '{1, 1, 1, 1,  7,  7, 15, 'h0100,  7, 1, 'h0020, 1, 1, 0};
      tv[27] = '{0, 1, 1, 1,  7,  7, 15, 'h0100,  0, 0, 'h0000, 0, 0, 0};
      rst_a = 1'b0;
      rst_b = 1'b0;
      {ifa.enable, ifa.play, ifa.loop_en, ifa.start_addr, ifa.end_addr, ifa.vol, ifa.rom_data} = '0;
      {ifb.enable, ifb.play, ifb.loop_en, ifb.start_addr, ifb.end_addr, ifb.vol, ifb.rom_data} = '0;
      for (int i = 0; i < 28; i++) begin
         rst_a          = tv[i].rst[0];
         ifa.enable     = tv[i].en[0];
         ifa.play       = tv[i].play[0];
         ifa.loop_en    = tv[i].lp[0];
         ifa.start_addr = tv[i].sa[17:0];
         ifa.end_addr   = tv[i].ea[17:0];
         ifa.vol        = tv[i].vol[3:0];
         ifa.rom_data   = tv[i].data[15:0];
         step();
         check($sformatf("v%0d_addr", i),    32'(ifa.rom_addr),     tv[i].e_addr);
         check($sformatf("v%0d_rden", i),    32'(ifa.rom_rden),     tv[i].e_rden);
         check($sformatf("v%0d_sample", i),  32'(ifa.sample_out),   tv[i].e_samp);
         check($sformatf("v%0d_valid", i),   32'(ifa.sample_valid), tv[i].e_valid);
         check($sformatf("v%0d_playing", i), 32'(ifa.playing),      tv[i].e_play);
         check($sformatf("v%0d_done", i),    32'(ifa.done),         tv[i].e_done);
      end
      // pause with fade-out, resume, then reset mid-run at address 100
      rst_a = 1'b1; ifa.enable = 1'b1; ifa.play = 1'b0; ifa.loop_en = 1'b0;
      ifa.start_addr = 18'd4; ifa.end_addr = 18'd200; ifa.vol = 4'd15; ifa.rom_data = 16'h0100;
      step();
      ifa.play = 1'b1;
      step();
      check("pz_start_addr", 32'(ifa.rom_addr), 4);
      for (int k = 1; k <= 16; k++) step();
      check("pz_addr20", 32'(ifa.rom_addr), 20);
      check("pz_samp_g15", 32'(ifa.sample_out), 'hF0);
      ifa.play = 1'b0;
      for (int j = 1; j <= 16; j++) begin
         step();
         check($sformatf("fade%0d_rden", j), 32'(ifa.rom_rden), 1);
         check($sformatf("fade%0d_addr", j), 32'(ifa.rom_addr), 32'(20 + j));
         check($sformatf("fade%0d_samp", j), 32'(ifa.sample_out), 32'(16 * (17 - j)));
      end
      step();
      check("pause_playing", 32'(ifa.playing), 0);
      check("pause_rden", 32'(ifa.rom_rden), 0);
      check("pause_addr", 32'(ifa.rom_addr), 37);
      check("pause_valid", 32'(ifa.sample_valid), 1);
      check("pause_samp", 32'(ifa.sample_out), 0);
      step();
      check("held_addr", 32'(ifa.rom_addr), 37);
      check("held_valid", 32'(ifa.sample_valid), 0);
      ifa.play = 1'b1;
      step();
      check("resume_playing", 32'(ifa.playing), 1);
      check("resume_rden", 32'(ifa.rom_rden), 1);
      check("resume_addr", 32'(ifa.rom_addr), 37);
      check("resume_valid", 32'(ifa.sample_valid), 0);
      step();
      check("resume1_addr", 32'(ifa.rom_addr), 38);
      check("resume1_samp", 32'(ifa.sample_out), 0);
      check("resume1_valid", 32'(ifa.sample_valid), 1);
      step();
      check("resume2_addr", 32'(ifa.rom_addr), 39);
      check("resume2_samp", 32'(ifa.sample_out), 'h10);
      for (int k = 40; k <= 100; k++) begin
         step();
         check($sformatf("run_addr%0d", k), 32'(ifa.rom_addr), 32'(k));
      end
      rst_a = 1'b0;
      step();
      check("rst_addr", 32'(ifa.rom_addr), 0);
      check("rst_rden", 32'(ifa.rom_rden), 0);
      check("rst_samp", 32'(ifa.sample_out), 0);
      check("rst_valid", 32'(ifa.sample_valid), 0);
      check("rst_playing", 32'(ifa.playing), 0);
      check("rst_done", 32'(ifa.done), 0);
      rst_a = 1'b1;
      // four-frame ramp divider on a full-scale sample
      rst_b = 1'b1; ifb.enable = 1'b1; ifb.play = 1'b1; ifb.loop_en = 1'b0;
      ifb.start_addr = 18'd0; ifb.end_addr = 18'd1000; ifb.vol = 4'd15; ifb.rom_data = 16'h7FFF;
      for (int n = 1; n <= 80; n++) begin
         if (n == 66) ifb.rom_data = 16'h8000;
         step();
         case (n)
            1: begin
               check("rb1_addr", 32'(ifb.rom_addr), 0);
               check("rb1_playing", 32'(ifb.playing), 1);
               check("rb1_valid", 32'(ifb.sample_valid), 0);
            end
            5:  check("rb5_samp_g1", 32'(ifb.sample_out), 'h07FF);
            32: check("rb32_samp_g7", 32'(ifb.sample_out), 'h37FF);
            33: check("rb33_samp_g8", 32'(ifb.sample_out), 'h3FFF);
            36: check("rb36_samp_g8", 32'(ifb.sample_out), 'h3FFF);
            64: check("rb64_samp_g15", 32'(ifb.sample_out), 'h77FF);
            65: check("rb65_samp_g16", 32'(ifb.sample_out), 'h7FFF);
            66: check("rb66_samp_neg", 32'(ifb.sample_out), 'h8000);
            80: begin
               check("rb80_samp_cap", 32'(ifb.sample_out), 'h8000);
               check("rb80_addr", 32'(ifb.rom_addr), 79);
            end
            default: ;
         endcase
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
